// File: rtl/mux_n_scan.sv
// Registered N:1 channel mux with a manual-select mode and an auto-scan
// sequencer that dwells DWELL enabled cycles on each channel in turn.
module mux_n_scan #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int DWELL = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [N*W-1:0] din_i,
  input  logic [SW-1:0]  sel_i,
  input  logic           auto_i,
  input  logic           en_i,
  output logic [W-1:0]   y_o,
  output logic [SW-1:0]  ch_o,
  output logic           valid_o,
  output logic           wrap_o
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CUR_LAST = SW'(N - 1);

  typedef enum logic {MANUAL, SCAN} state_e;

  state_e              state_q, state_d;
  logic [N-1:0][W-1:0] chan;
  logic [W-1:0]        y_q, y_d;
  logic [SW-1:0]       ch_q, ch_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;
  logic [SW-1:0]       cur_q, cur_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       scan_cur;
  logic [CW-1:0]       scan_cnt;
  logic                sel_legal;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = din_i[k*W +: W];
  end

  // Integer compare so the check stays meaningful when N is a power of two.
  assign sel_legal = int'(sel_i) < N;

  // The first SCAN edge after MANUAL always starts at channel 0, first dwell.
  assign scan_cur = (state_q == MANUAL) ? '0 : cur_q;
  assign scan_cnt = (state_q == MANUAL) ? '0 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= MANUAL;
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = auto_i ? SCAN : MANUAL;
    y_d     = y_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    cur_d   = scan_cur;
    cnt_d   = scan_cnt;
    if (!auto_i) begin
      cur_d = '0;
      cnt_d = '0;
      if (en_i) begin
        ch_d    = sel_i;
        valid_d = sel_legal;
        y_d     = sel_legal ? chan[sel_i] : '0;
      end
    end else if (en_i) begin
      y_d     = chan[scan_cur];
      ch_d    = scan_cur;
      valid_d = 1'b1;
      if (scan_cnt == CNT_LAST) begin
        cnt_d  = '0;
        cur_d  = (scan_cur == CUR_LAST) ? '0 : scan_cur + SW'(1);
        wrap_d = (scan_cur == CUR_LAST);
      end else begin
        cnt_d = scan_cnt + CW'(1);
      end
    end
  end

  assign y_o     = y_q;
  assign ch_o    = ch_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_mux_n_scan.sv
// Scoreboard bench for mux_n_scan (N=4, W=8, DWELL=2): directed scenarios then
// randomized traffic, checked against a scan-position model.
module tb_mux_n_scan;
  localparam int N = 4, W = 8, DWELL = 2, SW = 2;
  localparam int FRAME = N * DWELL;

  logic           clk = 1'b0;
  logic           reset, auto_m, en;
  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           valid, wrap;

  mux_n_scan #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk_i(clk), .reset_i(reset), .din_i(din), .sel_i(sel), .auto_i(auto_m),
    .en_i(en), .y_o(y), .ch_o(ch), .valid_o(valid), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  y;
    logic [SW-1:0] ch;
    logic          v;
    logic          w;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0, cyc = 0;

  // Reference: one frame position 0..FRAME-1; channel = pos / DWELL.
  int            pos = 0;
  logic [W-1:0]  m_y = '0;
  int            m_ch = 0;
  logic          m_v = 1'b0, m_w = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      m_y = '0; m_ch = 0; m_v = 1'b0; m_w = 1'b0; pos = 0;
    end else if (!auto_m) begin
      pos = 0;
      m_w = 1'b0;
      if (en) begin
        m_ch = int'(sel);
        m_v  = (m_ch < N);
        m_y  = m_v ? din[m_ch*W +: W] : '0;
      end else m_v = 1'b0;
    end else if (en) begin
      m_ch = pos / DWELL;
      m_y  = din[m_ch*W +: W];
      m_v  = 1'b1;
      m_w  = (pos == FRAME - 1);
      pos  = (pos + 1) % FRAME;
    end else begin
      m_v = 1'b0; m_w = 1'b0;
    end
    e.y = m_y; e.ch = SW'(m_ch); e.v = m_v; e.w = m_w;
    q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL cyc%0d scoreboard: no expected entry, got y=%h ch=%0d", cyc, y, ch);
    end else begin
      e = q.pop_front();
      if (y !== e.y || ch !== e.ch || valid !== e.v || wrap !== e.w) begin
        errors++;
        $display("FAIL cyc%0d outputs: got y=%h ch=%0d valid=%b wrap=%b, expected y=%h ch=%0d valid=%b wrap=%b",
                 cyc, y, ch, valid, wrap, e.y, e.ch, e.v, e.w);
      end
    end
  end

  task automatic step(input logic r, input logic a, input logic e, input logic [SW-1:0] s);
    reset = r; auto_m = a; en = e; sel = s;
    @(negedge clk);
  endtask

  initial begin
    din = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    // reset with en/auto high
    step(1, 1, 1, 0); step(1, 1, 1, 0);
    // manual walk
    for (int i = 0; i < N; i++) step(0, 0, 1, SW'(i));
    // full scan frame plus one
    for (int i = 0; i < 9; i++) step(0, 1, 1, 0);
    // stall at first ch=1 output
    step(0, 0, 1, 0);
    step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0); step(0, 1, 1, 0);
    // mode drop at ch=2, then re-enter
    step(0, 1, 1, 0);
    step(0, 0, 1, 1);
    step(0, 1, 1, 3); step(0, 1, 1, 3);
    // reset mid-scan at ch=3
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    // randomized traffic
    auto_m = 1'b1;
    for (int i = 0; i < 800; i++) begin
      logic a;
      din = {$urandom, $urandom} ;
      a = ($urandom_range(0, 9) == 0) ? ~auto_m : auto_m;
      step(($urandom_range(0, 59) == 0), a, ($urandom_range(0, 3) != 0),
           SW'($urandom_range(0, N - 1)));
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
